keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/sync2.sv | 26 ++
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding,
// row/column-to-key-code table and the blank key value used at reset.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;

   // Blank digit on the 7-segment decoder.
   localparam logic [3:0] KEY_RESET = 4'hF;

   // Entry index is {row, col}; highest index first in the concatenation.
   // row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E(*) 0 F(#) D
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : synchronized output
module sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce on press and release.
//   clk, rst_n  : clock, async active-low reset
//   row_n[3:0]  : keypad rows, active-low, asynchronous
//   col_n[3:0]  : column drive, active-low one-hot
//   key[3:0]    : code of last accepted key (F after reset)
//   key_valid   : one-cycle pulse on acceptance of a new key
//   key_pressed : high while the accepted key is held
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned DEBOUNCE_N = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_pressed
);

   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned MW = $clog2(DEBOUNCE_N + 1);

   logic [3:0]    rows_s;
   logic [DW-1:0] dwell;
   logic [MW-1:0] match;
   logic [1:0]    col_idx;
   logic [1:0]    cap_row;
   logic [1:0]    cap_col;
   state_t        state;

   logic          sample_c;
   logic          any_low_c;
   logic [1:0]    low_row_c;
   logic [MW-1:0] match_inc_c;
   logic          match_done_c;
   logic          cap_low_c;

   sync2 #(.WIDTH(4)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_n),
      .q     (rows_s)
   );

   // Sample strobe at the end of each column dwell.
   assign sample_c = (dwell == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell <= '0;
      end else if (sample_c) begin
         dwell <= '0;
      end else begin
         dwell <= dwell + DW'(1);
      end
   end

   // Lowest-index low row wins.
   always_comb begin
      any_low_c = ~&rows_s;
      low_row_c = 2'd0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rows_s[i]) low_row_c = 2'(i);
      end
   end

   // Saturating next match count and whether it reaches the threshold.
   assign match_inc_c  = (match >= MW'(DEBOUNCE_N)) ? match : match + MW'(1);
   assign match_done_c = (match_inc_c >= MW'(DEBOUNCE_N));
   assign cap_low_c    = ~rows_s[cap_row];

   // Scan / debounce / hold / release FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_SCAN;
         col_n       <= 4'b1110;
         col_idx     <= 2'd0;
         cap_row     <= 2'd0;
         cap_col     <= 2'd0;
         match       <= '0;
         key         <= KEY_RESET;
         key_valid   <= 1'b0;
         key_pressed <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (sample_c) begin
            unique case (state)
               ST_SCAN: begin
                  if (any_low_c) begin
                     cap_row <= low_row_c;
                     cap_col <= col_idx;
                     match   <= MW'(1);
                     if (DEBOUNCE_N <= 1) begin
                        key         <= key_code(low_row_c, col_idx);
                        key_valid   <= 1'b1;
                        key_pressed <= 1'b1;
                        state       <= ST_HELD;
                     end else begin
                        state <= ST_DEBOUNCE;
                     end
                  end else begin
                     col_n   <= {col_n[2:0], col_n[3]};
                     col_idx <= col_idx + 2'd1;
                  end
               end
               ST_DEBOUNCE: begin
                  if (cap_low_c) begin
                     match <= match_inc_c;
                     if (match_done_c) begin
                        key         <= key_code(cap_row, cap_col);
                        key_valid   <= 1'b1;
                        key_pressed <= 1'b1;
                        state       <= ST_HELD;
                     end
                  end else begin
                     col_n   <= {col_n[2:0], col_n[3]};
                     col_idx <= col_idx + 2'd1;
                     state   <= ST_SCAN;
                  end
               end
               ST_HELD: begin
                  if (!cap_low_c) begin
                     match <= MW'(1);
                     if (DEBOUNCE_N <= 1) begin
                        key_pressed <= 1'b0;
                        col_n       <= {col_n[2:0], col_n[3]};
                        col_idx     <= col_idx + 2'd1;
                        state       <= ST_SCAN;
                     end else begin
                        state <= ST_RELEASE;
                     end
                  end
               end
               ST_RELEASE: begin
                  if (cap_low_c) begin
                     // Bounce back to held without a new pulse.
                     state <= ST_HELD;
                  end else begin
                     match <= match_inc_c;
                     if (match_done_c) begin
                        key_pressed <= 1'b0;
                        col_n       <= {col_n[2:0], col_n[3]};
                        col_idx     <= col_idx + 2'd1;
                        state       <= ST_SCAN;
                     end
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_N=3.
// A behavioural keypad pulls a row low while a pressed key's column is driven.
module tb_keypad_scanner;

   localparam int unsigned SCAN_DIV   = 4;
   localparam int unsigned DEBOUNCE_N = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key;
   logic        key_valid;
   logic        key_pressed;

   logic [15:0] pressed;   // bit r*4+c
   int          checks;
   int          failures;
   int          vcount;
   int          dbl;
   logic        prev_kv;
   int          v0;

   keypad_scanner #(
      .SCAN_DIV   (SCAN_DIV),
      .DEBOUNCE_N (DEBOUNCE_N)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_n       (row_n),
      .col_n       (col_n),
      .key         (key),
      .key_valid   (key_valid),
      .key_pressed (key_pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix model.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   // Pulse monitor: counts key_valid pulses and back-to-back highs.
   initial begin
      vcount  = 0;
      dbl     = 0;
      prev_kv = 1'b0;
   end
   always @(negedge clk) begin
      if (key_valid) vcount = vcount + 1;
      if (key_valid && prev_kv) dbl = dbl + 1;
      prev_kv = key_valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic samples(input int n);
      repeat (n * SCAN_DIV) @(negedge clk);
   endtask

   function automatic logic [15:0] kbit(input int r, input int c);
      logic [15:0] m;
      m = 16'h0;
      m[r*4 + c] = 1'b1;
      return m;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      pressed  = 16'h0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_col_n", 32'(col_n), 32'hE);
      check("rst_key", 32'(key), 32'hF);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_key_pressed", 32'(key_pressed), 32'h0);

      // Short press on row0/col0: 2 samples only, then release.
      pressed = kbit(0, 0);
      rst_n   = 1'b1;
      samples(2);
      check("bounce_col_frozen", 32'(col_n), 32'hE);
      pressed = 16'h0;
      samples(1);
      check("bounce_col_resume", 32'(col_n), 32'hD);
      check("bounce_key", 32'(key), 32'hF);
      check("bounce_no_valid", 32'(vcount), 32'd0);
      samples(1);
      check("bounce_col2", 32'(col_n), 32'hB);

      // '6' (row1/col2) held for 20 samples.
      pressed = kbit(1, 2);
      samples(20);
      check("six_valid_count", 32'(vcount), 32'd1);
      check("six_key", 32'(key), 32'h6);
      check("six_pressed", 32'(key_pressed), 32'h1);
      check("six_col_frozen", 32'(col_n), 32'hB);

      // Press '0' (row3/col1) while '6' is held: ignored.
      pressed = kbit(1, 2) | kbit(3, 1);
      samples(3);
      check("ignore_other_valid", 32'(vcount), 32'd1);
      check("ignore_other_key", 32'(key), 32'h6);
      check("ignore_other_col", 32'(col_n), 32'hB);

      // Release '6' for 3 samples; '0' stays pressed.
      pressed = kbit(3, 1);
      samples(3);
      check("six_released", 32'(key_pressed), 32'h0);
      check("six_release_col", 32'(col_n), 32'h7);
      samples(8);
      check("zero_key", 32'(key), 32'h0);
      check("zero_valid_count", 32'(vcount), 32'd2);
      check("zero_pressed", 32'(key_pressed), 32'h1);
      check("zero_col_frozen", 32'(col_n), 32'hD);

      // Release for 2 samples then press again: stays held.
      pressed = 16'h0;
      samples(2);
      check("rel2_still_pressed", 32'(key_pressed), 32'h1);
      pressed = kbit(3, 1);
      samples(2);
      check("repress_pressed", 32'(key_pressed), 32'h1);
      check("repress_no_valid", 32'(vcount), 32'd2);
      check("repress_key", 32'(key), 32'h0);
      pressed = 16'h0;
      samples(4);
      check("zero_released", 32'(key_pressed), 32'h0);

      // Rows 0 and 2 low together on col0: row0 wins -> '1'.
      rst_n = 1'b0;
      @(negedge clk);
      v0      = vcount;
      pressed = kbit(0, 0) | kbit(2, 0);
      rst_n   = 1'b1;
      samples(2);
      check("multi_debouncing_key", 32'(key), 32'hF);
      check("multi_debouncing_pressed", 32'(key_pressed), 32'h0);
      samples(2);
      check("multi_key", 32'(key), 32'h1);
      check("multi_one_pulse", 32'(vcount - v0), 32'd1);
      check("multi_pressed", 32'(key_pressed), 32'h1);

      // Asynchronous reset mid-HELD takes effect before the next edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_col_n", 32'(col_n), 32'hE);
      check("async_key", 32'(key), 32'hF);
      check("async_key_valid", 32'(key_valid), 32'h0);
      check("async_key_pressed", 32'(key_pressed), 32'h0);
      pressed = 16'h0;
      @(negedge clk);
      rst_n = 1'b1;
      check("restart_col0", 32'(col_n), 32'hE);
      samples(1);
      check("restart_col1", 32'(col_n), 32'hD);
      check("restart_key", 32'(key), 32'hF);

      check("no_double_pulse", 32'(dbl), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
